// File: rtl/esc_pkg.sv
// Shared types and default timing constants for the four-channel ESC PWM generator.
// Optional build macro used by the channels: ESC_SLEW_LIMIT_EN.
package esc_pkg;

  typedef logic [10:0] spd_t;
  typedef logic [14:0] pw_t;

  typedef enum logic [0:0] {
    ARM = 1'b0,
    RUN = 1'b1
  } esc_state_t;

  localparam int MIN_PULSE_DFLT = 6250;
  localparam int SPD_GAIN_DFLT  = 3;
  localparam int SPD_MAX        = 2047;

endpackage

// File: rtl/esc_chan.sv
// One ESC channel: shadow/active speed banks, pulse-width register and frame compare.
// Build macro ESC_SLEW_LIMIT_EN enables per-frame slew limiting of the active speed in RUN.
module esc_chan
  import esc_pkg::*;
#(
  parameter int PERIOD_W  = 18,
  parameter int MIN_PULSE = MIN_PULSE_DFLT,
  parameter int SPD_GAIN  = SPD_GAIN_DFLT,
  parameter int MAX_STEP  = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                spd_vld,
  input  spd_t                spd,
  input  logic                load,
  input  logic                run,
  input  logic [PERIOD_W-1:0] cnt,
  output logic                pwm
);

  // The widest pulse must fit both the pw register and the frame.
  if (MIN_PULSE < 2 || MIN_PULSE + SPD_GAIN * SPD_MAX >= 2 ** PERIOD_W ||
      MIN_PULSE + SPD_GAIN * SPD_MAX >= 2 ** 15) begin : g_bad_pulse_cfg
    $error("esc_chan: pulse width range does not fit the frame or pw_t");
  end
  if (MAX_STEP < 1 || MAX_STEP > SPD_MAX) begin : g_bad_step_cfg
    $error("esc_chan: MAX_STEP out of range");
  end

  spd_t shadow;
  spd_t active;
  spd_t active_nxt;
  pw_t  pw;
  pw_t  pw_eff;

`ifdef ESC_SLEW_LIMIT_EN
  localparam logic signed [11:0] STEP = 12'(MAX_STEP);
  logic signed [11:0] diff;
  logic signed [11:0] step;

  always_comb begin
    diff = $signed({1'b0, shadow}) - $signed({1'b0, active});
    step = diff;
    if (diff > STEP) begin
      step = STEP;
    end else if (diff < -STEP) begin
      step = -STEP;
    end
    active_nxt = run ? spd_t'(12'(active) + step) : shadow;
  end
`else
  assign active_nxt = shadow;
`endif

  // pw lags active by one cycle; the cnt==1 compare still sees the old pw,
  // which is harmless because every pw is at least MIN_PULSE >= 2.
  assign pw_eff = run ? pw : pw_t'(MIN_PULSE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow <= '0;
      active <= '0;
      pw     <= '0;
      pwm    <= 1'b0;
    end else begin
      if (spd_vld) begin
        shadow <= spd;
      end
      if (load) begin
        active <= active_nxt;
      end
      pw  <= pw_t'(MIN_PULSE + SPD_GAIN * int'(active));
      pwm <= (32'(cnt) < 32'(pw_eff));
    end
  end

endmodule

// File: rtl/esc_pwm_gen.sv
// Four-channel ESC PWM generator: shared frame counter, arming sequencer and four esc_chan.
// Build macro ESC_SLEW_LIMIT_EN (see esc_chan) adds slew limiting of speed changes.
//
//   state | meaning
//   ARM   | forced MIN_PULSE output; count frame starts up to ARM_FRAMES
//   RUN   | pulse widths follow commanded speeds until reset
module esc_pwm_gen
  import esc_pkg::*;
#(
  parameter int PERIOD_W   = 18,
  parameter int MIN_PULSE  = MIN_PULSE_DFLT,
  parameter int SPD_GAIN   = SPD_GAIN_DFLT,
  parameter int ARM_FRAMES = 4,
  parameter int MAX_STEP   = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spd_vld,
  input  logic [10:0] frnt_spd,
  input  logic [10:0] bck_spd,
  input  logic [10:0] lft_spd,
  input  logic [10:0] rght_spd,
  output logic        frnt_pwm,
  output logic        bck_pwm,
  output logic        lft_pwm,
  output logic        rght_pwm,
  output logic        frm_strt,
  output logic        armed
);

  if (ARM_FRAMES < 1) begin : g_bad_arm_cfg
    $error("esc_pwm_gen: ARM_FRAMES must be at least 1");
  end

  localparam int ARM_W = $clog2(ARM_FRAMES + 1);

  logic [PERIOD_W-1:0] cnt;
  logic [ARM_W-1:0]    arm_cnt;
  esc_state_t          state;
  logic                frm_zero;
  logic                run;
  spd_t                spd_v [4];
  logic [3:0]          pwm_v;

  assign frm_zero = (cnt == '0);
  assign run      = (state == RUN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      frm_strt <= 1'b0;
      arm_cnt  <= '0;
      state    <= ARM;
      armed    <= 1'b0;
    end else begin
      cnt      <= cnt + PERIOD_W'(1);
      frm_strt <= frm_zero;
      if (frm_zero && state == ARM) begin
        if (arm_cnt == ARM_W'(ARM_FRAMES)) begin
          state <= RUN;
          armed <= 1'b1;
        end else begin
          arm_cnt <= arm_cnt + ARM_W'(1);
        end
      end
    end
  end

  assign spd_v[0] = frnt_spd;
  assign spd_v[1] = bck_spd;
  assign spd_v[2] = lft_spd;
  assign spd_v[3] = rght_spd;

  for (genvar i = 0; i < 4; i++) begin : g_chan
    esc_chan #(
      .PERIOD_W (PERIOD_W),
      .MIN_PULSE(MIN_PULSE),
      .SPD_GAIN (SPD_GAIN),
      .MAX_STEP (MAX_STEP)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .spd_vld(spd_vld),
      .spd    (spd_v[i]),
      .load   (frm_zero),
      .run    (run),
      .cnt    (cnt),
      .pwm    (pwm_v[i])
    );
  end

  assign frnt_pwm = pwm_v[0];
  assign bck_pwm  = pwm_v[1];
  assign lft_pwm  = pwm_v[2];
  assign rght_pwm = pwm_v[3];

endmodule

// File: tb/tb_esc_pwm_gen.sv
// Self-checking bench for esc_pwm_gen with a shortened frame (PERIOD_W=12, MIN_PULSE=100, gain 1).
// A frame-level reference model checks every cycle; tables and sequences check measured widths.
module tb_esc_pwm_gen;

  localparam int PW    = 12;
  localparam int FRAME = 1 << PW;
  localparam int MIN   = 100;
  localparam int GAIN  = 1;
  localparam int ARMF  = 4;
  localparam int STEP  = 64;
  localparam int MEAS  = 2300;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        spd_vld;
  logic [10:0] spd [4];
  logic        frnt_pwm, bck_pwm, lft_pwm, rght_pwm, frm_strt, armed;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  esc_pwm_gen #(
    .PERIOD_W  (PW),
    .MIN_PULSE (MIN),
    .SPD_GAIN  (GAIN),
    .ARM_FRAMES(ARMF),
    .MAX_STEP  (STEP)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .spd_vld (spd_vld),
    .frnt_spd(spd[0]),
    .bck_spd (spd[1]),
    .lft_spd (spd[2]),
    .rght_spd(spd[3]),
    .frnt_pwm(frnt_pwm),
    .bck_pwm (bck_pwm),
    .lft_pwm (lft_pwm),
    .rght_pwm(rght_pwm),
    .frm_strt(frm_strt),
    .armed   (armed)
  );

  typedef struct packed {
    logic [3:0][10:0] spd;
    logic [3:0][15:0] w;
  } vec_t;

  vec_t tbl [4];

  function automatic vec_t mk(input int f, b, l, r, wf, wb, wl, wr);
    vec_t v;
    v.spd[0] = 11'(f); v.spd[1] = 11'(b); v.spd[2] = 11'(l); v.spd[3] = 11'(r);
    v.w[0]   = 16'(wf); v.w[1] = 16'(wb); v.w[2] = 16'(wl); v.w[3] = 16'(wr);
    return v;
  endfunction

  // Reference model: frame index since reset, position in frame, per-channel widths.
  int m_cnt, m_frame, m_pos;
  int m_shadow [4];
  int m_active [4];
  int m_w [4];

`ifdef ESC_SLEW_LIMIT_EN
  function automatic int clamp_step(input int d);
    if (d > STEP) return STEP;
    if (d < -STEP) return -STEP;
    return d;
  endfunction
`endif

  task automatic model_edge();
    if (!rst_n) begin
      m_cnt = 0; m_frame = 0; m_pos = 0;
      for (int i = 0; i < 4; i++) begin
        m_shadow[i] = 0; m_active[i] = 0; m_w[i] = 0;
      end
    end else begin
      if (m_cnt == 0) begin
        m_frame++;
        m_pos = 0;
        for (int i = 0; i < 4; i++) begin
`ifdef ESC_SLEW_LIMIT_EN
          if (m_frame >= ARMF + 2) m_active[i] = m_active[i] + clamp_step(m_shadow[i] - m_active[i]);
          else m_active[i] = m_shadow[i];
`else
          m_active[i] = m_shadow[i];
`endif
          m_w[i] = (m_frame <= ARMF) ? MIN : MIN + GAIN * m_active[i];
        end
      end else begin
        m_pos++;
      end
      if (spd_vld) for (int i = 0; i < 4; i++) m_shadow[i] = int'(spd[i]);
      m_cnt = (m_cnt + 1) % FRAME;
    end
  endtask

  function automatic logic [5:0] model_out();
    logic [5:0] e;
    e = '0;
    if (m_frame > 0) begin
      for (int i = 0; i < 4; i++) e[5-i] = (m_pos < m_w[i]);
      e[1] = (m_pos == 0);
      e[0] = (m_frame > ARMF);
    end
    return e;
  endfunction

  function automatic logic [5:0] outs();
    return {frnt_pwm, bck_pwm, lft_pwm, rght_pwm, frm_strt, armed};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check($sformatf("cycle@%0t", $time), 32'(outs()), 32'(model_out()));
  endtask

  task automatic wait_frame();
    for (int i = 0; i < FRAME + 8; i++) begin
      tick();
      if (frm_strt === 1'b1) return;
    end
    check("frame_timeout", 0, 1);
  endtask

  // Starts at the first high cycle of a frame; optionally strobes new speeds at sample vld_at.
  task automatic measure(input int vld_at, input int f, b, l, r, output int w [4]);
    for (int i = 0; i < 4; i++) w[i] = 0;
    for (int k = 0; k < MEAS; k++) begin
      w[0] += int'(frnt_pwm); w[1] += int'(bck_pwm);
      w[2] += int'(lft_pwm);  w[3] += int'(rght_pwm);
      if (k == vld_at) begin
        spd[0] = 11'(f); spd[1] = 11'(b); spd[2] = 11'(l); spd[3] = 11'(r);
        spd_vld = 1'b1;
      end
      tick();
      spd_vld = 1'b0;
    end
  endtask

  task automatic check_w(input string tag, input int w [4], input int e0, e1, e2, e3);
    check({tag, "_front"}, w[0], e0);
    check({tag, "_back"},  w[1], e1);
    check({tag, "_left"},  w[2], e2);
    check({tag, "_right"}, w[3], e3);
  endtask

  initial begin
    int w [4];
    int sl [5];

    tbl[0] = mk(0, 100, 1000, 2047, 100, 200, 1100, 2147);
    tbl[1] = mk(2047, 1, 512, 7, 2147, 101, 612, 107);
    tbl[2] = mk(1234, 2046, 0, 999, 1334, 2146, 100, 1099);
    tbl[3] = mk(0, 0, 0, 0, 100, 100, 100, 100);
    sl = '{164, 228, 292, 356, 400};

    rst_n = 1'b0; spd_vld = 1'b0;
    for (int i = 0; i < 4; i++) spd[i] = '0;
    tick(); tick();
    check("reset_outputs", 32'(outs()), 0);

    // Arming: full-scale command captured on the very first frame-start edge.
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) spd[i] = 11'd2047;
    spd_vld = 1'b1;
    tick();
    spd_vld = 1'b0;
    check("frm_strt_first", 32'(frm_strt), 1);
    for (int f = 1; f <= 5; f++) begin
      if (f > 1) wait_frame();
      check($sformatf("armed_frame%0d", f), 32'(armed), (f == 5) ? 1 : 0);
      measure(-1, 0, 0, 0, 0, w);
      if (f < 5) check_w($sformatf("arm_f%0d", f), w, 100, 100, 100, 100);
      else       check_w("first_run", w, 2147, 2147, 2147, 2147);
    end

`ifndef ESC_SLEW_LIMIT_EN
    for (int e = 0; e < 4; e++) begin
      for (int i = 0; i < 4; i++) spd[i] = tbl[e].spd[i];
      spd_vld = 1'b1;
      tick();
      spd_vld = 1'b0;
      wait_frame();
      measure(-1, 0, 0, 0, 0, w);
      check_w($sformatf("tbl%0d", e), w, int'(tbl[e].w[0]), int'(tbl[e].w[1]),
              int'(tbl[e].w[2]), int'(tbl[e].w[3]));
    end

    // Mid-frame strobe at cnt==100: current pulse unchanged, next frame updated.
    wait_frame();
    measure(99, 500, 0, 0, 0, w);
    check("midvld_cur_front", w[0], 100);
    wait_frame();
    measure(-1, 0, 0, 0, 0, w);
    check("midvld_next_front", w[0], 600);

    // Strobe on the cnt==0 edge applies one frame later.
    for (int i = 0; i < FRAME - 1 - MEAS; i++) tick();
    spd[0] = 11'd1500; spd[1] = '0; spd[2] = '0; spd[3] = '0;
    spd_vld = 1'b1;
    tick();
    spd_vld = 1'b0;
    check("zero_edge_frm_strt", 32'(frm_strt), 1);
    measure(-1, 0, 0, 0, 0, w);
    check("zero_edge_cur_front", w[0], 600);
    wait_frame();
    measure(-1, 0, 0, 0, 0, w);
    check("zero_edge_next_front", w[0], 1600);
`endif

    // One-cycle reset in the middle of a pulse, then arming restarts.
    wait_frame();
    for (int i = 0; i < 50; i++) tick();
    rst_n = 1'b0;
    tick();
    check("midreset_outputs", 32'(outs()), 0);
    rst_n = 1'b1;
    for (int f = 1; f <= 5; f++) begin
      wait_frame();
      check($sformatf("rearm_armed%0d", f), 32'(armed), (f == 5) ? 1 : 0);
      measure(-1, 0, 0, 0, 0, w);
      check_w($sformatf("rearm_f%0d", f), w, 100, 100, 100, 100);
    end

`ifdef ESC_SLEW_LIMIT_EN
    spd[0] = 11'd300; spd[1] = '0; spd[2] = '0; spd[3] = '0;
    spd_vld = 1'b1;
    tick();
    spd_vld = 1'b0;
    for (int j = 0; j < 5; j++) begin
      wait_frame();
      measure(-1, 0, 0, 0, 0, w);
      check($sformatf("slew_front%0d", j), w[0], sl[j]);
    end
`else
    // Random strobes with random speeds, checked cycle by cycle against the model.
    for (int c = 0; c < 2 * FRAME; c++) begin
      if ($urandom_range(299) == 0) begin
        for (int i = 0; i < 4; i++) spd[i] = 11'($urandom_range(2047));
        spd_vld = 1'b1;
      end
      tick();
      spd_vld = 1'b0;
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
